video_out_load: RTL and testbench

Wishbone master that reads one frame from RAM and pushes it, 32 bits (4 pixels) per word, into the video output FIFO. It is the read-side mirror of the video input store path. The processor supplies the frame base address through the control/data register pair. The block raises an interrupt once the whole frame has been fetched.

---
 rtl/video_pkg.sv | 23 ++
 rtl/video_out_wb_read.sv | 38 +++
 rtl/video_out_load.sv | 131 +++++++++++++
 tb/tb_video_out_load.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the video frame store/load Wishbone masters.
package video_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROOM,
        READ,
        WAIT_ACK,
        IRQ
    } vid_state_t;

    localparam int unsigned IRQ_CYCLES = 3;
    localparam int unsigned DEF_WIDTH  = 640;
    localparam int unsigned DEF_HEIGHT = 480;

    // 8-bit pixels packed four to a 32-bit word
    function automatic int unsigned frame_words(input int unsigned width, input int unsigned height);
        return (width * height) / 4;
    endfunction

    localparam int unsigned FRAME_WORDS = frame_words(DEF_WIDTH, DEF_HEIGHT);

endpackage

// File: rtl/video_out_wb_read.sv
// Single-word Wishbone read initiator: registered STB/CYC/ADR, termination reported combinationally.
module video_out_wb_read (
    input  logic        clk,
    input  logic        nRST,
    input  logic        start,
    input  logic [31:0] addr,
    output logic        done,
    output logic        err,
    output logic [31:0] data,
    output logic        wb_stb,
    output logic        wb_cyc,
    output logic [31:0] wb_adr,
    input  logic [31:0] wb_dat,
    input  logic        wb_ack,
    input  logic        wb_err
);

    // Terminations outside an open cycle are ignored
    assign done = wb_cyc & (wb_ack | wb_err);
    assign err  = wb_cyc & wb_err;
    assign data = wb_dat;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wb_stb <= 1'b0;
            wb_cyc <= 1'b0;
            wb_adr <= '0;
        end else if (done) begin
            wb_stb <= 1'b0;
            wb_cyc <= 1'b0;
        end else if (start && !wb_cyc) begin
            wb_stb <= 1'b1;
            wb_cyc <= 1'b1;
            wb_adr <= addr;
        end
    end

endmodule

// File: rtl/video_out_load.sv
// Reads one frame from RAM over Wishbone and pushes it, one 32-bit word per write, into the video output FIFO.
module video_out_load
    import video_pkg::*;
#(
    parameter int unsigned p_WIDTH  = 640,
    parameter int unsigned p_HEIGHT = 480,
    parameter int unsigned NB_PACK  = 16
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] wb_reg_ctr,
    input  logic [31:0] wb_reg_data,
    input  logic        fifo_room,
    output logic [31:0] fifo_data,
    output logic        fifo_we,
    output logic        interrupt,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_LOCK_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    input  logic [31:0] p_wb_DAT_I,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I
);

    localparam int unsigned FW   = frame_words(p_WIDTH, p_HEIGHT);
    localparam int unsigned WC_W = $clog2(FW + 1);
    localparam int unsigned BC_W = $clog2(NB_PACK + 1);

    vid_state_t        state;
    logic              old_ctr0;
    logic [31:0]       base;
    logic [WC_W-1:0]   word_cnt;
    logic [BC_W-1:0]   burst_cnt;
    logic [1:0]        irq_cnt;

    logic              new_addr;
    logic              rd_start;
    logic              rd_done;
    logic              rd_err;
    logic [31:0]       rd_addr;
    logic [31:0]       rd_data;
    logic              ctr_unused;

    assign new_addr   = wb_reg_ctr[0] & ~old_ctr0;
    assign ctr_unused = ^wb_reg_ctr[31:1];
    assign rd_start   = (state == READ);
    assign rd_addr    = base + (32'(word_cnt) << 2);

    assign p_wb_LOCK_O = 1'b0;
    assign p_wb_WE_O   = 1'b0;
    assign p_wb_SEL_O  = 4'hf;

    video_out_wb_read u_rd (
        .clk    (clk),
        .nRST   (nRST),
        .start  (rd_start),
        .addr   (rd_addr),
        .done   (rd_done),
        .err    (rd_err),
        .data   (rd_data),
        .wb_stb (p_wb_STB_O),
        .wb_cyc (p_wb_CYC_O),
        .wb_adr (p_wb_ADR_O),
        .wb_dat (p_wb_DAT_I),
        .wb_ack (p_wb_ACK_I),
        .wb_err (p_wb_ERR_I)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            old_ctr0  <= 1'b0;
            base      <= '0;
            word_cnt  <= '0;
            burst_cnt <= '0;
            irq_cnt   <= '0;
            interrupt <= 1'b0;
            fifo_we   <= 1'b0;
            fifo_data <= '0;
        end else begin
            old_ctr0 <= wb_reg_ctr[0];
            fifo_we  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (new_addr) begin
                        base     <= wb_reg_data;
                        word_cnt <= '0;
                        state    <= WAIT_ROOM;
                    end
                end
                WAIT_ROOM: begin
                    burst_cnt <= BC_W'(NB_PACK);
                    if (fifo_room)
                        state <= READ;
                end
                READ: state <= WAIT_ACK;
                WAIT_ACK: begin
                    // An errored read still consumes a FIFO slot so pixel alignment is preserved
                    if (rd_done) begin
                        fifo_we   <= 1'b1;
                        fifo_data <= rd_err ? '0 : rd_data;
                        word_cnt  <= word_cnt + 1'b1;
                        burst_cnt <= burst_cnt - 1'b1;
                        if (word_cnt == WC_W'(FW - 1)) begin
                            state     <= IRQ;
                            interrupt <= 1'b1;
                            irq_cnt   <= '0;
                        end else if (burst_cnt == BC_W'(1)) begin
                            state <= WAIT_ROOM;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                IRQ: begin
                    if (irq_cnt == 2'(IRQ_CYCLES - 1)) begin
                        interrupt <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        irq_cnt <= irq_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_out_load.sv
// Directed bench for video_out_load against a word-list model of the frame fetch.
module tb_video_out_load;

    localparam int unsigned W      = 32;
    localparam int unsigned H      = 16;
    localparam int unsigned NPACK  = 16;
    localparam int unsigned NWORDS = W * H / 4;

    logic        clk = 1'b0;
    logic        nRST;
    logic [31:0] wb_reg_ctr;
    logic [31:0] wb_reg_data;
    logic        fifo_room;
    logic [31:0] fifo_data;
    logic        fifo_we;
    logic        interrupt;
    logic        stb, cyc, lock, we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic        ack, err;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    int unsigned exp_base, exp_rd, exp_wr, err_idx, waits;
    int unsigned irq_len, irq_pulses, wcnt;
    logic        stb_prev;
    logic        room_gap;
    logic [31:0] last_adr, w0_seen, w5_seen;

    video_out_load #(.p_WIDTH(W), .p_HEIGHT(H), .NB_PACK(NPACK)) dut (
        .clk         (clk),
        .nRST        (nRST),
        .wb_reg_ctr  (wb_reg_ctr),
        .wb_reg_data (wb_reg_data),
        .fifo_room   (fifo_room),
        .fifo_data   (fifo_data),
        .fifo_we     (fifo_we),
        .interrupt   (interrupt),
        .p_wb_STB_O  (stb),
        .p_wb_CYC_O  (cyc),
        .p_wb_LOCK_O (lock),
        .p_wb_WE_O   (we),
        .p_wb_SEL_O  (sel),
        .p_wb_ADR_O  (adr),
        .p_wb_DAT_I  (dat_i),
        .p_wb_ACK_I  (ack),
        .p_wb_ERR_I  (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
        end
    endtask

    // Behavioural slave: memory image, programmable wait states, one errored word index
    always @(negedge clk) begin
        if (!nRST || !(stb && cyc)) begin
            ack  = 1'b0;
            err  = 1'b0;
            wcnt = 0;
        end else if (ack || err) begin
            ack = 1'b0;
            err = 1'b0;
        end else if (wcnt == waits) begin
            wcnt = 0;
            if (((adr - exp_base) >> 2) == err_idx) begin
                err   = 1'b1;
                dat_i = 32'hDEAD_BEEF;
            end else begin
                ack   = 1'b1;
                dat_i = mem(adr);
            end
        end else begin
            wcnt++;
        end
    end

    // Scoreboard: frame is the word list base+4k, k = 0..NWORDS-1, data = mem() except the errored word
    always @(negedge clk) begin
        if (!nRST) begin
            stb_prev = 1'b0;
            irq_len  = 0;
        end else begin
            if (stb) begin
                check("bus_const", {27'd0, we, lock, sel != 4'hf, cyc, 1'b0}, 32'h2);
                if (room_gap)
                    check("stb_in_gap", 32'(stb), 32'h0);
            end
            if (stb && !stb_prev) begin
                check("read_adr", adr, exp_base + (exp_rd << 2));
                last_adr = adr;
                exp_rd++;
            end
            stb_prev = stb;
            if (fifo_we) begin
                check("fifo_data", fifo_data,
                      (exp_wr == err_idx) ? 32'h0 : mem(exp_base + (exp_wr << 2)));
                if (exp_wr == 0) w0_seen = fifo_data;
                if (exp_wr == 5) w5_seen = fifo_data;
                exp_wr++;
            end
            if (interrupt) begin
                irq_len++;
            end else if (irq_len != 0) begin
                check("irq_len", 32'(irq_len), 32'd3);
                check("irq_after_last_word", exp_wr, NWORDS);
                irq_pulses++;
                irq_len = 0;
            end
        end
    end

    task automatic reset_dut(input logic [31:0] base, input int unsigned ws, input int unsigned eidx);
        @(negedge clk);
        nRST       = 1'b0;
        wb_reg_ctr = '0;
        fifo_room  = 1'b1;
        room_gap   = 1'b0;
        exp_base   = base;
        exp_rd     = 0;
        exp_wr     = 0;
        irq_pulses = 0;
        waits      = ws;
        err_idx    = eidx;
        w0_seen    = 32'hFFFF_FFFF;
        w5_seen    = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_frame(input logic [31:0] base);
        wb_reg_data = base;
        wb_reg_ctr  = 32'h1;
    endtask

    task automatic wait_frame(input string name);
        for (int i = 0; i < 5000 && irq_pulses == 0; i++) @(negedge clk);
        check(name, 32'(irq_pulses), 32'd1);
        check({name, "_words"}, exp_wr, NWORDS);
    endtask

    task automatic wait_writes(input int unsigned n);
        for (int i = 0; i < 5000 && exp_wr < n; i++) @(negedge clk);
        check("wait_writes", 32'(exp_wr >= n), 32'h1);
    endtask

    initial begin
        nRST        = 1'b0;
        wb_reg_ctr  = '0;
        wb_reg_data = '0;
        fifo_room   = 1'b1;
        room_gap    = 1'b0;
        dat_i       = '0;
        ack         = 1'b0;
        err         = 1'b0;
        waits       = 0;
        err_idx     = 32'hFFFF_FFFF;
        exp_base    = 0;
        irq_pulses  = 0;
        repeat (2) @(negedge clk);
        check("rst_outs", {24'd0, stb, cyc, lock, we, fifo_we, interrupt, 2'b00}, 32'h0);
        check("rst_adr", adr, 32'h0);
        check("rst_fifo_data", fifo_data, 32'h0);

        // 1: zero-wait slave, full frame, start latency
        reset_dut(32'h1000_0000, 0, 32'hFFFF_FFFF);
        start_frame(32'h1000_0000);
        @(negedge clk); check("lat_t1", 32'(stb), 32'h0);
        @(negedge clk); check("lat_t2", 32'(stb), 32'h0);
        @(negedge clk); check("lat_t3", 32'(stb), 32'h1);
        check("first_adr", adr, 32'h1000_0000);
        wait_frame("t1_frame");
        check("t1_last_adr", last_adr, 32'h1000_01FC);
        check("t1_word0", w0_seen, 32'hBEEF_1000);
        repeat (5) @(negedge clk);
        check("t1_idle_after_irq", {30'd0, stb, interrupt}, 32'h0);
        check("t1_single_irq", 32'(irq_pulses), 32'd1);

        // 2: FIFO room withdrawn after the first burst
        reset_dut(32'h1100_0000, 0, 32'hFFFF_FFFF);
        start_frame(32'h1100_0000);
        for (int i = 0; i < 2000 && exp_wr < 16; i++) begin
            @(negedge clk);
            if (fifo_we && exp_wr == 15) break;
        end
        fifo_room = 1'b0;
        room_gap  = 1'b1;
        repeat (50) @(negedge clk);
        check("t2_no_write_in_gap", exp_wr, 32'd16);
        room_gap  = 1'b0;
        fifo_room = 1'b1;
        for (int i = 0; i < 10 && !stb; i++) @(negedge clk);
        check("t2_resume_adr", adr, 32'h1100_0040);
        wait_frame("t2_frame");

        // 3: three wait states, ERR on word 5
        reset_dut(32'h1200_0000, 3, 5);
        start_frame(32'h1200_0000);
        wait_frame("t3_frame");
        check("t3_word5_zero", w5_seen, 32'h0);
        check("t3_last_adr", last_adr, 32'h1200_01FC);

        // 4: new_addr mid-frame is ignored
        reset_dut(32'h1300_0000, 0, 32'hFFFF_FFFF);
        start_frame(32'h1300_0000);
        wait_writes(20);
        wb_reg_ctr = '0;
        @(negedge clk);
        start_frame(32'h2000_0000);
        wait_frame("t4_frame");
        check("t4_last_adr", last_adr, 32'h1300_01FC);

        // 5: asynchronous reset while word 100 is on the bus
        reset_dut(32'h1400_0000, 1, 32'hFFFF_FFFF);
        start_frame(32'h1400_0000);
        for (int i = 0; i < 5000 && !(stb && adr == 32'h1400_0190); i++) @(negedge clk);
        check("t5_reached_word100", 32'(stb), 32'h1);
        nRST = 1'b0;
        #1;
        check("t5_async_drop", {29'd0, stb, cyc, fifo_we}, 32'h0);
        wb_reg_ctr = '0;
        exp_base   = 32'h1500_0000;
        exp_rd     = 0;
        exp_wr     = 0;
        irq_pulses = 0;
        waits      = 0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_quiet_after_rst", {30'd0, stb, fifo_we}, 32'h0);
        start_frame(32'h1500_0000);
        wait_frame("t5_frame");
        check("t5_last_adr", last_adr, 32'h1500_01FC);

        // 6: ctr bit held high through reset release counts as an edge
        @(negedge clk);
        nRST        = 1'b0;
        exp_base    = 32'h1600_0000;
        exp_rd      = 0;
        exp_wr      = 0;
        irq_pulses  = 0;
        wb_reg_data = 32'h1600_0000;
        wb_reg_ctr  = 32'h1;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_stb", 32'(stb), 32'h1);
        check("t6_first_adr", adr, 32'h1600_0000);
        wait_frame("t6_frame");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
